mdu_issue_ctrl: RTL

E-stage front end for the multiply/divide unit of the P6 pipeline. Decodes the E-stage MDU operation, drives the MDU's `start`/`mod`/`d1`/`d2` inputs, and tracks the unit's multi-cycle occupancy with its own latency FSM. Raises `stall` to the hazard unit while a later MDU instruction would collide with an in-flight operation, and returns HI/LO to the E-stage result mux for `mfhi`/`mflo`.

---
 rtl/mdu_issue_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage front end for the multiply/divide unit.
// Decodes the E-stage MDU op, launches the MDU, and mirrors its occupancy
// with a latency FSM (IDLE/MUL/DIV plus a down-counter) so later MDU
// instructions stall until the unit is free.
//
// Optional feature: define MDU_CTRL_DIV0_GUARD_EN to suppress div/divu
// issue when the divisor (e_rt) is zero (no start, HI/LO untouched, no stall).
//
// Handshake: there is no valid/ready pair here. The MDU samples mdu_start
// and mdu_mod on the rising edge that ends the issue cycle. The hazard unit
// holds D/E for every cycle that stall is high. An instruction in E is
// consumed on the first cycle where stall is low.
module mdu_issue_ctrl #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        mdu_start,
    output logic [2:0]  mdu_mod,
    output logic [31:0] mdu_d1,
    output logic [31:0] mdu_d2,
    output logic        stall,
    output logic        ctrl_busy,
    output logic [31:0] e_mdu_result,
    output logic [1:0]  dbg_state
);

    // MDU mode encodings shared with the MDU (define_file.v mdu_* values)
    localparam logic [2:0] MDU_MUL_SIGNED   = 3'd1;
    localparam logic [2:0] MDU_MUL_UNSIGNED = 3'd2;
    localparam logic [2:0] MDU_DIV_SIGNED   = 3'd3;
    localparam logic [2:0] MDU_DIV_UNSIGNED = 3'd4;
    localparam logic [2:0] MDU_MOVETO_HI    = 3'd5;
    localparam logic [2:0] MDU_MOVETO_LO    = 3'd6;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       issue;
    logic       is_mdu_op;
    logic       div_blocked;

    assign issue     = e_valid & ~flush & ~rst & (state == IDLE);
    assign is_mdu_op = (e_op >= OP_MULT) && (e_op <= OP_MFLO);

`ifdef MDU_CTRL_DIV0_GUARD_EN
    assign div_blocked = (e_rt == 32'd0);
`else
    assign div_blocked = 1'b0;
`endif

    // Operands go straight through; the MDU only acts on them with start/moveto.
    assign mdu_d1    = e_rs;
    assign mdu_d2    = e_rt;
    assign stall     = ~rst & e_valid & is_mdu_op & (state != IDLE);
    assign ctrl_busy = ~rst & (state != IDLE);
    assign dbg_state = state;

    // HI/LO read-back mux for mfhi/mflo
    always_comb begin
        e_mdu_result = 32'd0;
        if (!rst) begin
            if (e_op == OP_MFHI)
                e_mdu_result = mdu_hi;
            else if (e_op == OP_MFLO)
                e_mdu_result = mdu_lo;
        end
    end

    // Next-state, counter and MDU launch decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mdu_start = 1'b0;
        mdu_mod   = MDU_MUL_SIGNED;
        case (state)
            IDLE: begin
                if (issue) begin
                    case (e_op)
                        OP_MULT, OP_MULTU: begin
                            mdu_start = 1'b1;
                            mdu_mod   = (e_op == OP_MULT) ? MDU_MUL_SIGNED : MDU_MUL_UNSIGNED;
                            cnt_nxt   = MUL_LOAD;
                            state_nxt = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (!div_blocked) begin
                                mdu_start = 1'b1;
                                mdu_mod   = (e_op == OP_DIV) ? MDU_DIV_SIGNED : MDU_DIV_UNSIGNED;
                                cnt_nxt   = DIV_LOAD;
                                state_nxt = DIV;
                            end
                        end
                        OP_MTHI: mdu_mod = MDU_MOVETO_HI;
                        OP_MTLO: mdu_mod = MDU_MOVETO_LO;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and occupancy counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
